// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the seven-segment scan decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: digit count, active-low segment codes for hex 0..F, scan FSM state type.
package seven_seg_pkg;

  localparam int NUM_DIGITS = 4;

  // Active-low segment codes, bit0 = a ... bit6 = g.
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  // Index i holds the code for hex value i.
  localparam logic [15:0][6:0] SEG_CODES = {
    SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
    SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
  };

  typedef enum logic [1:0] {
    ST_IDLE,    // no digit enable asserted
    ST_SETTLE,  // a digit is enabled, waiting for the pattern to settle
    ST_HELD     // this stable window has already been evaluated
  } scan_state_t;

endpackage

// File: rtl/seven_seg_pattern_decode.sv
// Maps an active-low seven-segment pattern to a hex nibble.
// Latency: combinational.
// Backpressure: none.
//
// Ports: segments (in, active-low a..g), pat_vld (out, pattern is a hex code),
//        pat_dat (out, decoded nibble, 0 when pat_vld is low).
module seven_seg_pattern_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0] segments,
  output logic       pat_vld,
  output logic [3:0] pat_dat
);

  always_comb begin
    pat_vld = 1'b0;
    pat_dat = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (segments == SEG_CODES[i]) begin
        pat_vld = 1'b1;
        pat_dat = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Recovers the four hex digits shown on a scanned, active-low seven-segment display.
// Latency: a digit held from cycle t is captured at edge t+2+STABLE_CYCLES; frame_valid one cycle after the 4th capture.
// Backpressure: none; the display is sampled continuously and frames are published as they complete.
//
// Ports: sys_clk, rst (async, active-high); segments[6:0] and seven_segs[3:0] (active-low, asynchronous);
//        digits[15:0] last complete frame (nibble n = digit n); frame_valid, pattern_err, anode_err (1-cycle pulses);
//        scan_stall (level, no capture within TIMEOUT_CYCLES).
// Optional feature: define SCAN_TIMEOUT_EN to build the stall timeout; otherwise scan_stall is tied low.
module seven_seg_scan_decoder
  import seven_seg_pkg::*;
#(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic [6:0]  segments,
  input  logic [3:0]  seven_segs,
  output logic [15:0] digits,
  output logic        frame_valid,
  output logic        pattern_err,
  output logic        anode_err,
  output logic        scan_stall
);

  localparam int SMP_W = NUM_DIGITS + 7;
  localparam logic [7:0] STABLE_MAX  = 8'(STABLE_CYCLES);
  localparam logic [7:0] STABLE_EVAL = 8'(STABLE_CYCLES - 1);

  logic [SMP_W-1:0]        sync1_q, sync1_d;
  logic [SMP_W-1:0]        sync2_q, sync2_d;
  logic [SMP_W-1:0]        prev_q, prev_d;
  logic [7:0]              cnt_q, cnt_d;
  scan_state_t             state_q, state_d;
  logic [NUM_DIGITS*4-1:0] staging_q, staging_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic [NUM_DIGITS*4-1:0] digits_q, digits_d;
  logic                    frame_valid_q, frame_valid_d;
  logic                    pattern_err_q, pattern_err_d;
  logic                    anode_err_q, anode_err_d;

  logic [NUM_DIGITS-1:0]   en_low;
  logic                    same;
  logic                    any_low;
  logic                    multi_low;
  logic                    eval;
  logic                    capture;
  logic                    pat_vld;
  logic [3:0]              pat_dat;

  seven_seg_pattern_decode u_decode (
    .segments (sync2_q[6:0]),
    .pat_vld  (pat_vld),
    .pat_dat  (pat_dat)
  );

  always_comb begin
    sync1_d = {seven_segs, segments};
    sync2_d = sync1_q;
    prev_d  = sync2_q;

    en_low    = ~sync2_q[SMP_W-1:7];
    same      = (sync2_q == prev_q);
    any_low   = |en_low;
    multi_low = ($countones(en_low) > 1);

    // Stability run length of the synchronized sample, saturating.
    cnt_d = '0;
    if (same) begin
      cnt_d = (cnt_q == STABLE_MAX) ? cnt_q : cnt_q + 8'd1;
    end

    // One evaluation per stable window: the edge that leaves SETTLE.
    eval    = same && (state_q != ST_HELD) && any_low && (cnt_q >= STABLE_EVAL);
    capture = eval && !multi_low && pat_vld;

    state_d = state_q;
    if (!same) begin
      state_d = any_low ? ST_SETTLE : ST_IDLE;
    end else if (state_q == ST_HELD) begin
      state_d = ST_HELD;
    end else if (!any_low) begin
      state_d = ST_IDLE;
    end else if (eval) begin
      state_d = ST_HELD;
    end else begin
      state_d = ST_SETTLE;
    end

    // Anode fault outranks pattern fault.
    anode_err_d   = eval && multi_low;
    pattern_err_d = eval && !multi_low && !pat_vld;

    staging_d     = staging_q;
    seen_d        = seen_q;
    digits_d      = digits_q;
    frame_valid_d = 1'b0;

    if (seen_q == '1) begin
      digits_d      = staging_q;
      frame_valid_d = 1'b1;
      seen_d        = '0;
    end

    // Applied after the frame clear so a same-edge capture starts the next frame.
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (capture && en_low[i]) begin
        staging_d[4*i +: 4] = pat_dat;
        seen_d[i]           = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      prev_q        <= '0;
      cnt_q         <= '0;
      state_q       <= ST_IDLE;
      staging_q     <= '0;
      seen_q        <= '0;
      digits_q      <= '0;
      frame_valid_q <= 1'b0;
      pattern_err_q <= 1'b0;
      anode_err_q   <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      prev_q        <= prev_d;
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      staging_q     <= staging_d;
      seen_q        <= seen_d;
      digits_q      <= digits_d;
      frame_valid_q <= frame_valid_d;
      pattern_err_q <= pattern_err_d;
      anode_err_q   <= anode_err_d;
    end
  end

  assign digits      = digits_q;
  assign frame_valid = frame_valid_q;
  assign pattern_err = pattern_err_q;
  assign anode_err   = anode_err_q;

`ifdef SCAN_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Cycles since the last successful capture, saturating at the limit.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (capture) begin
      tmo_cnt_d = '0;
    end else if (tmo_cnt_q != TMO_MAX) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign scan_stall = (tmo_cnt_q == TMO_MAX);
`else
  // Timeout compiled out; the term keeps the parameter referenced.
  assign scan_stall = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
module tb_seven_seg_scan_decoder;

  localparam int STABLE  = 16;
  localparam int TIMEOUT = 1000;
  localparam int K_FV = 4;
  localparam int K_PE = 2;
  localparam int K_AE = 1;

  logic        sys_clk;
  logic        rst;
  logic [6:0]  segments;
  logic [3:0]  seven_segs;
  logic [15:0] digits;
  logic        frame_valid;
  logic        pattern_err;
  logic        anode_err;
  logic        scan_stall;

  typedef struct {
    int          kind;
    logic [15:0] dig;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;

  seven_seg_scan_decoder #(
    .STABLE_CYCLES  (STABLE),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .segments    (segments),
    .seven_segs  (seven_segs),
    .digits      (digits),
    .frame_valid (frame_valid),
    .pattern_err (pattern_err),
    .anode_err   (anode_err),
    .scan_stall  (scan_stall)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every output pulse must match the oldest pending expectation.
  always @(negedge sys_clk) begin
    if (!rst && (frame_valid || pattern_err || anode_err)) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_event: got fv=%0b pe=%0b ae=%0b digits=%h with nothing expected (cycle %0d)",
                 frame_valid, pattern_err, anode_err, digits, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("event_kind", {29'd0, frame_valid, pattern_err, anode_err}, e.kind);
        check("event_cycle", cyc, e.cyc);
        if (e.kind == K_FV) check("frame_digits", {16'd0, digits}, {16'd0, e.dig});
      end
    end
  end

  // Drive one display state; an expected pulse is queued with its exact arrival cycle.
  task automatic show(input logic [3:0] en, input logic [6:0] seg, input int hold,
                      input int kind, input logic [15:0] dig);
    exp_t e;
    @(posedge sys_clk);
    #1;
    seven_segs = en;
    segments   = seg;
    if (kind != 0) begin
      e.kind = kind;
      e.dig  = dig;
      e.cyc  = cyc + 3 + STABLE + ((kind == K_FV) ? 1 : 0);
      exp_q.push_back(e);
    end
    repeat (hold - 1) @(posedge sys_clk);
  endtask

  task automatic check_cleared(input string tag);
    @(negedge sys_clk);
    check({tag, "_digits"},      {16'd0, digits}, 32'd0);
    check({tag, "_frame_valid"}, {31'd0, frame_valid}, 32'd0);
    check({tag, "_pattern_err"}, {31'd0, pattern_err}, 32'd0);
    check({tag, "_anode_err"},   {31'd0, anode_err}, 32'd0);
    check({tag, "_scan_stall"},  {31'd0, scan_stall}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    segments   = 7'h7F;
    seven_segs = 4'hF;
    repeat (3) @(posedge sys_clk);
    check_cleared("reset");
    @(posedge sys_clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge sys_clk);

    // Basic scan, 1000 cycles per digit.
    show(4'b0111, 7'h79, 1000, 0, 16'h0);
    show(4'b1011, 7'h24, 1000, 0, 16'h0);
    show(4'b1101, 7'h30, 1000, 0, 16'h0);
    show(4'b1110, 7'h19, 1000, K_FV, 16'h1234);
    // Remaining codes across three more frames.
    show(4'b0111, 7'h08, 200, 0, 16'h0);
    show(4'b1011, 7'h12, 200, 0, 16'h0);
    show(4'b1101, 7'h46, 200, 0, 16'h0);
    show(4'b1110, 7'h40, 200, K_FV, 16'hA5C0);
    show(4'b0111, 7'h03, 200, 0, 16'h0);
    show(4'b1011, 7'h21, 200, 0, 16'h0);
    show(4'b1101, 7'h06, 200, 0, 16'h0);
    show(4'b1110, 7'h0E, 200, K_FV, 16'hBDEF);
    show(4'b0111, 7'h02, 200, 0, 16'h0);
    show(4'b1011, 7'h78, 200, 0, 16'h0);
    show(4'b1101, 7'h00, 200, 0, 16'h0);
    show(4'b1110, 7'h10, 200, K_FV, 16'h6789);

    // Undecodable digit 0 blocks the frame; digit 3 is overwritten on the repeat scan.
    show(4'b0111, 7'h30, 200, 0, 16'h0);
    show(4'b1011, 7'h24, 200, 0, 16'h0);
    show(4'b1101, 7'h79, 200, 0, 16'h0);
    show(4'b1110, 7'h7F, 200, K_PE, 16'h0);
    show(4'b0111, 7'h19, 200, 0, 16'h0);
    show(4'b1011, 7'h24, 200, 0, 16'h0);
    show(4'b1101, 7'h79, 200, 0, 16'h0);
    show(4'b1110, 7'h7F, 200, K_PE, 16'h0);
    show(4'b1110, 7'h12, 200, K_FV, 16'h4215);

    // Multiple enables low mid-frame: anode_err only, nothing written.
    show(4'b0111, 7'h79, 200, 0, 16'h0);
    show(4'b1011, 7'h79, 200, 0, 16'h0);
    show(4'b0011, 7'h24, 200, K_AE, 16'h0);
    show(4'b0011, 7'h7F, 200, K_AE, 16'h0);
    show(4'b0000, 7'h40, 200, K_AE, 16'h0);
    show(4'b1101, 7'h79, 200, 0, 16'h0);
    show(4'b1110, 7'h06, 200, K_FV, 16'h111E);

    // Inputs changing every 8 cycles never settle.
    for (int i = 0; i < 30; i++) begin
      show((i % 2) ? 4'b1011 : 4'b0111, (i % 2) ? 7'h24 : 7'h79, 8, 0, 16'h0);
    end
    show(4'b1111, 7'h7F, 100, 0, 16'h0);

    // Reset after three captures discards the partial frame.
    show(4'b0111, 7'h79, 200, 0, 16'h0);
    show(4'b1011, 7'h24, 200, 0, 16'h0);
    show(4'b1101, 7'h30, 200, 0, 16'h0);
    @(posedge sys_clk);
    #1;
    rst        = 1'b1;
    segments   = 7'h7F;
    seven_segs = 4'hF;
    repeat (2) @(posedge sys_clk);
    check_cleared("midreset");
    @(posedge sys_clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge sys_clk);
    show(4'b1110, 7'h00, 200, 0, 16'h0);
    show(4'b1101, 7'h10, 200, 0, 16'h0);
    show(4'b1011, 7'h02, 200, 0, 16'h0);
    show(4'b0111, 7'h78, 200, K_FV, 16'h7698);
    show(4'b1111, 7'h7F, 50, 0, 16'h0);

`ifdef SCAN_TIMEOUT_EN
    // Frozen all-high display: stall rises exactly TIMEOUT edges after reset release.
    @(posedge sys_clk);
    #1 rst = 1'b1;
    @(posedge sys_clk);
    #1 rst = 1'b0;
    repeat (TIMEOUT - 1) @(posedge sys_clk);
    @(negedge sys_clk);
    check("stall_before_limit", {31'd0, scan_stall}, 32'd0);
    @(posedge sys_clk);
    @(negedge sys_clk);
    check("stall_at_limit", {31'd0, scan_stall}, 32'd1);
    show(4'b0111, 7'h79, STABLE + 1, 0, 16'h0);
    @(negedge sys_clk);
    check("stall_held_until_capture", {31'd0, scan_stall}, 32'd1);
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("stall_cleared_by_capture", {31'd0, scan_stall}, 32'd0);
`else
    repeat (300) @(posedge sys_clk);
    @(negedge sys_clk);
    check("stall_tied_low", {31'd0, scan_stall}, 32'd0);
`endif

    repeat (50) @(posedge sys_clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
